// File: rtl/riscv_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package riscv_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } trap_state_e;

    // Kind of event latched on entry to FLUSH
    typedef enum logic [1:0] {
        TRAP = 2'd0,
        MRET = 2'd1,
        IRQ  = 2'd2
    } trap_kind_e;

    // Interrupt bit set, cause 11: machine external interrupt
    localparam logic [31:0] MCAUSE_EXT_IRQ_DFLT = 32'h8000_000B;

    // Direct-mode trap vector: mtvec with the mode bits cleared
    function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
        return mtvec & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// N-flop level synchronizer for an asynchronous interrupt line.
module irq_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] r_sync;

    // Shift the raw level through the chain; only the last flop is consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], d_i};
        end
    end

    assign q_o = r_sync[N-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap / interrupt entry and MRET return sequencer.
// Watches WB, latches the winning event, then runs FLUSH -> REDIRECT.
module trap_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned IRQ_SYNC_STAGES = 2,
    parameter logic [31:0] MCAUSE_EXT_IRQ  = MCAUSE_EXT_IRQ_DFLT,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wb_valid_i,
    input  logic             wb_trap_valid_i,
    input  logic             wb_is_mret_i,
    input  logic [31:0]      wb_pc_i,
    input  logic [31:0]      wb_next_pc_i,
    input  logic [31:0]      wb_trap_mcause_i,
    input  logic [31:0]      wb_trap_mtval_i,
    input  logic [31:0]      mtvec_i,
    input  logic [31:0]      mepc_i,
    input  logic             mie_i,
    input  logic             irq_i,
    input  logic             redirect_ready_i,
    output logic             flush_o,
    output logic             busy_o,
    output logic             csr_trap_we_o,
    output logic [31:0]      csr_mepc_o,
    output logic [31:0]      csr_mcause_o,
    output logic [31:0]      csr_mtval_o,
    output logic             mie_clear_o,
    output logic             mie_restore_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] trap_count_o
);

    trap_state_e      r_state;
    trap_state_e      w_state_next;
    trap_kind_e       r_kind;
    logic [31:0]      r_mepc;
    logic [31:0]      r_mcause;
    logic [31:0]      r_mtval;
    logic [31:0]      r_target;
    logic [CNT_W-1:0] r_cnt;

    logic w_irq_sync;
    logic w_irq_pend;
    logic w_sel_trap;
    logic w_sel_mret;
    logic w_sel_irq;
    logic w_evt;

    irq_sync #(
        .N (IRQ_SYNC_STAGES)
    ) u_irq_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (irq_i),
        .q_o    (w_irq_sync)
    );

    assign w_irq_pend = w_irq_sync & mie_i;

    // Fixed-priority event selection; only evaluated while IDLE
    always_comb begin
        w_sel_trap = 1'b0;
        w_sel_mret = 1'b0;
        w_sel_irq  = 1'b0;
        if (r_state == IDLE && wb_valid_i) begin
            if (wb_trap_valid_i) begin
                w_sel_trap = 1'b1;
            end else if (wb_is_mret_i) begin
                w_sel_mret = 1'b1;
            end else if (w_irq_pend) begin
                w_sel_irq = 1'b1;
            end
        end
        w_evt = w_sel_trap | w_sel_mret | w_sel_irq;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs (no input reaches the outputs)
    always_comb begin
        w_state_next     = r_state;
        flush_o          = 1'b0;
        busy_o           = 1'b0;
        csr_trap_we_o    = 1'b0;
        mie_clear_o      = 1'b0;
        mie_restore_o    = 1'b0;
        redirect_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_evt) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush_o      = 1'b1;
                busy_o       = 1'b1;
                w_state_next = REDIRECT;
                if (r_kind == MRET) begin
                    mie_restore_o = 1'b1;
                end else begin
                    csr_trap_we_o = 1'b1;
                    mie_clear_o   = 1'b1;
                end
            end
            REDIRECT: begin
                flush_o          = 1'b1;
                busy_o           = 1'b1;
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Latch event kind and CSR/redirect data; held until the next event
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_kind   <= TRAP;
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_target <= '0;
        end else if (w_sel_trap) begin
            r_kind   <= TRAP;
            r_mepc   <= wb_pc_i;
            r_mcause <= wb_trap_mcause_i;
            r_mtval  <= wb_trap_mtval_i;
            r_target <= mtvec_base(mtvec_i);
        end else if (w_sel_mret) begin
            r_kind   <= MRET;
            r_target <= mepc_i;
        end else if (w_sel_irq) begin
            // The WB instruction retires, so the return point is its successor
            r_kind   <= IRQ;
            r_mepc   <= wb_next_pc_i;
            r_mcause <= MCAUSE_EXT_IRQ;
            r_mtval  <= '0;
            r_target <= mtvec_base(mtvec_i);
        end
    end

    // Saturating entry counter, bumped alongside the CSR write strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == FLUSH && r_kind != MRET && r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign csr_mepc_o    = r_mepc;
    assign csr_mcause_o  = r_mcause;
    assign csr_mtval_o   = r_mtval;
    assign redirect_pc_o = r_target;
    assign trap_count_o  = r_cnt;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge. An 8-bit counter keeps the
// saturation run short.
module tb_trap_ctrl;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_valid, wb_trap, wb_mret;
    logic [31:0]   wb_pc, wb_npc, wb_mcause, wb_mtval, mtvec, mepc;
    logic          mie, irq, ready;
    logic          flush, busy, we, mclr, mrst, rvalid;
    logic [31:0]   o_mepc, o_mcause, o_mtval, rpc;
    logic [CW-1:0] cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trap_ctrl #(
        .IRQ_SYNC_STAGES (2),
        .MCAUSE_EXT_IRQ  (32'h8000_000B),
        .CNT_W           (CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .wb_valid_i       (wb_valid),
        .wb_trap_valid_i  (wb_trap),
        .wb_is_mret_i     (wb_mret),
        .wb_pc_i          (wb_pc),
        .wb_next_pc_i     (wb_npc),
        .wb_trap_mcause_i (wb_mcause),
        .wb_trap_mtval_i  (wb_mtval),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .mie_i            (mie),
        .irq_i            (irq),
        .redirect_ready_i (ready),
        .flush_o          (flush),
        .busy_o           (busy),
        .csr_trap_we_o    (we),
        .csr_mepc_o       (o_mepc),
        .csr_mcause_o     (o_mcause),
        .csr_mtval_o      (o_mtval),
        .mie_clear_o      (mclr),
        .mie_restore_o    (mrst),
        .redirect_valid_o (rvalid),
        .redirect_pc_o    (rpc),
        .trap_count_o     (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_strobes(input string tag, input logic f, input logic w,
                               input logic c, input logic r, input logic v);
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
        chk({tag, ".we"},    {31'd0, we},    {31'd0, w});
        chk({tag, ".clr"},   {31'd0, mclr},  {31'd0, c});
        chk({tag, ".rst"},   {31'd0, mrst},  {31'd0, r});
        chk({tag, ".rval"},  {31'd0, rvalid},{31'd0, v});
    endtask

    task automatic wb_idle();
        wb_valid = 1'b0; wb_trap = 1'b0; wb_mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b0; irq = 1'b0; mie = 1'b1;
        wb_idle();
        wb_pc = '0; wb_npc = '0; wb_mcause = '0; wb_mtval = '0;
        mtvec = 32'h2001; mepc = 32'h344;

        // Reset state
        repeat (2) @(negedge clk);
        chk_strobes("reset", 0, 0, 0, 0, 0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.cnt", {24'd0, cnt}, 32'd0);
        chk("reset.rpc", rpc, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Illegal-instruction trap, redirect held off for 5 cycles
        wb_valid = 1'b1; wb_trap = 1'b1; wb_pc = 32'h100;
        wb_mcause = 32'd2; wb_mtval = 32'hDEADBEEF;
        @(negedge clk);
        wb_idle();
        $display("txn trap pc=100 flush cycle");
        chk_strobes("trap.flush", 1, 1, 1, 0, 0);
        chk("trap.busy", {31'd0, busy}, 32'd1);
        chk("trap.mepc", o_mepc, 32'h100);
        chk("trap.mcause", o_mcause, 32'd2);
        chk("trap.mtval", o_mtval, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_strobes("trap.hold", 1, 0, 0, 0, 1);
            chk("trap.hold.pc", rpc, 32'h2000);
        end
        chk("trap.cnt", {24'd0, cnt}, 32'd1);
        ready = 1'b1;
        @(negedge clk);
        chk_strobes("trap.idle", 0, 0, 0, 0, 0);
        chk("trap.idle.busy", {31'd0, busy}, 32'd0);

        // MRET with a single-cycle redirect
        wb_valid = 1'b1; wb_mret = 1'b1;
        @(negedge clk);
        wb_idle();
        $display("txn mret mepc=344");
        chk_strobes("mret.flush", 1, 0, 0, 1, 0);
        @(negedge clk);
        chk_strobes("mret.redir", 1, 0, 0, 0, 1);
        chk("mret.pc", rpc, 32'h344);
        chk("mret.cnt", {24'd0, cnt}, 32'd1);
        @(negedge clk);
        chk("mret.idle.busy", {31'd0, busy}, 32'd0);

        // External interrupt, MIE set: two synchronizer cycles before entry
        irq = 1'b1; wb_valid = 1'b1; wb_npc = 32'h204;
        @(negedge clk);
        chk("irq.sync1.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("irq.sync2.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        irq = 1'b0; wb_idle();
        $display("txn irq npc=204");
        chk_strobes("irq.flush", 1, 1, 1, 0, 0);
        chk("irq.mepc", o_mepc, 32'h204);
        chk("irq.mcause", o_mcause, 32'h8000000B);
        chk("irq.mtval", o_mtval, 32'd0);
        @(negedge clk);
        chk("irq.pc", rpc, 32'h2000);
        chk("irq.cnt", {24'd0, cnt}, 32'd2);
        @(negedge clk);
        chk("irq.idle.busy", {31'd0, busy}, 32'd0);

        // External interrupt, MIE clear: never taken
        mie = 1'b0; irq = 1'b1; wb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("irqmasked.busy", {31'd0, busy}, 32'd0);
        end
        $display("txn irq masked");
        irq = 1'b0; wb_idle();
        repeat (3) @(negedge clk);

        // Trap + MRET + IRQ together: trap wins, IRQ follows the handshake
        mie = 1'b1; irq = 1'b1; ready = 1'b0;
        repeat (2) @(negedge clk);
        wb_valid = 1'b1; wb_trap = 1'b1; wb_mret = 1'b1;
        wb_pc = 32'h300; wb_npc = 32'h304; wb_mcause = 32'd7; wb_mtval = 32'h55;
        @(negedge clk);
        wb_trap = 1'b0; wb_mret = 1'b0;
        $display("txn trap+mret+irq");
        chk_strobes("multi.flush", 1, 1, 1, 0, 0);
        chk("multi.mepc", o_mepc, 32'h300);
        chk("multi.mcause", o_mcause, 32'd7);
        @(negedge clk);
        chk("multi.pc", rpc, 32'h2000);
        ready = 1'b1;
        @(negedge clk);
        chk("multi.idle.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        irq = 1'b0; wb_idle();
        $display("txn pending irq taken npc=304");
        chk_strobes("multi.irq.flush", 1, 1, 1, 0, 0);
        chk("multi.irq.mepc", o_mepc, 32'h304);
        chk("multi.irq.mcause", o_mcause, 32'h8000000B);
        repeat (2) @(negedge clk);
        chk("multi.cnt", {24'd0, cnt}, 32'd4);
        chk("multi.idle2.busy", {31'd0, busy}, 32'd0);

        // Reset while in REDIRECT
        ready = 1'b0;
        wb_valid = 1'b1; wb_trap = 1'b1; wb_pc = 32'h400;
        @(negedge clk);
        wb_idle();
        @(negedge clk);
        chk("rstmid.rval", {31'd0, rvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn reset in redirect");
        chk_strobes("rstmid", 0, 0, 0, 0, 0);
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.cnt", {24'd0, cnt}, 32'd0);
        chk("rstmid.rpc", rpc, 32'd0);
        chk("rstmid.mepc", o_mepc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_strobes("rstpost", 0, 0, 0, 0, 0);
        end

        // Saturation: continuous traps, one entry every 3 cycles
        ready = 1'b1;
        wb_valid = 1'b1; wb_trap = 1'b1;
        repeat (3 * 254) @(negedge clk);
        chk("sat.254", {24'd0, cnt}, 32'd254);
        repeat (3 * 3) @(negedge clk);
        wb_idle();
        repeat (3) @(negedge clk);
        $display("txn saturation 257 entries");
        chk("sat.max", {24'd0, cnt}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences machine-mode trap entry, interrupt entry and MRET return for the 5-stage core. Sits beside the CSR register file.
- Watches the WB stage and arbitrates between synchronous traps, MRET and a machine external interrupt.
- Issues the pipeline flush, one-cycle CSR update strobes (mepc/mcause/mtval, MIE clear/restore) and a handshaked PC redirect to fetch.

Parameters:
IRQ_SYNC_STAGES, 2, number of flops in the irq_i synchronizer (>=2)
MCAUSE_EXT_IRQ, 32'h8000_000B, mcause value written on external-interrupt entry
CNT_W, 16, width of the saturating trap-entry counter

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
wb_valid_i  in  1  WB holds a valid instruction
wb_trap_valid_i  in  1  WB instruction raised a synchronous exception
wb_is_mret_i  in  1  WB instruction is MRET
wb_pc_i  in  32  PC of WB instruction
wb_next_pc_i  in  32  architectural next PC of WB instruction
wb_trap_mcause_i  in  32  exception cause from pipeline
wb_trap_mtval_i  in  32  exception value from pipeline
mtvec_i  in  32  current mtvec
mepc_i  in  32  current mepc
mie_i  in  1  mstatus.MIE
irq_i  in  1  asynchronous level external interrupt
redirect_ready_i  in  1  fetch accepts the redirect
flush_o  out  1  squash IF..WB
busy_o  out  1  controller not in IDLE; hazard unit stalls ID
csr_trap_we_o  out  1  one-cycle strobe to write mepc/mcause/mtval
csr_mepc_o  out  32  mepc write data
csr_mcause_o  out  32  mcause write data
csr_mtval_o  out  32  mtval write data
mie_clear_o  out  1  one-cycle strobe: MPIE<=MIE, MIE<=0
mie_restore_o  out  1  one-cycle strobe: MIE<=MPIE
redirect_valid_o  out  1  redirect request to fetch
redirect_pc_o  out  32  redirect target
trap_count_o  out  CNT_W  saturating count of trap and interrupt entries

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All outputs and capture registers go to 0.
  - Synchronizer flops clear.
  - Reset mid-sequence abandons the sequence; no strobe is emitted after release.
- irq_sync: irq_i passes through IRQ_SYNC_STAGES flops.
  - irq_pend = irq_sync & mie_i.
- Event selection in IDLE, gated by wb_valid_i, fixed priority:
  1. TRAP: wb_trap_valid_i. Captures mepc=wb_pc_i, mcause=wb_trap_mcause_i, mtval=wb_trap_mtval_i, target={mtvec_i[31:2],2'b00}.
  2. MRET: wb_is_mret_i. Captures target=mepc_i.
  3. IRQ: irq_pend. The WB instruction retires. Captures mepc=wb_next_pc_i, mcause=MCAUSE_EXT_IRQ, mtval=0, target={mtvec_i[31:2],2'b00}.
  - A selected event registers its kind and data on the clock edge and moves the FSM to FLUSH.
  - With no event, the FSM stays in IDLE.
- FLUSH (exactly 1 cycle):
  - flush_o=1.
  - TRAP/IRQ: csr_trap_we_o=1 and mie_clear_o=1; trap_count_o increments, saturating at all-ones.
  - MRET: mie_restore_o=1.
  - Next state is REDIRECT.
- REDIRECT:
  - flush_o=1, redirect_valid_o=1, redirect_pc_o=captured target.
  - Target and data are held stable until redirect_ready_i=1 at a clock edge; then the FSM goes to IDLE.
  - redirect_ready_i may already be high on entry, giving a 1-cycle REDIRECT.
- busy_o=1 in FLUSH and REDIRECT.
  - All WB events are ignored while busy_o=1, including irq, which stays pending and is re-evaluated in IDLE.
- Minimum latency from event cycle to redirect_valid_o is 2 cycles.
- csr_*_o data outputs are registered and valid whenever csr_trap_we_o=1.
- Strobes are single-cycle and never overlap. csr_trap_we_o and mie_restore_o are mutually exclusive.
- Back-to-back events: a new event is accepted on the first IDLE cycle after the handshake.
- No combinational path from any input to flush_o, csr_trap_we_o or redirect_valid_o.
  - Exception: busy_o is registered-state only.

Decomposition:
- Shared package (riscv_pkg):
  - trap_state_e: IDLE, FLUSH, REDIRECT.
  - trap_kind_e: TRAP, MRET, IRQ.
  - MCAUSE_EXT_IRQ default constant.
- One sub-module, irq_sync: parameterized N-flop synchronizer with async active-low reset.

Test Plan:
- Illegal-instruction trap (wb_pc=0x100, mcause=2, mtval=0xDEADBEEF, mtvec=0x2001):
  - Expect: FLUSH cycle with csr_trap_we_o=1, mepc=0x100, mcause=2, mtval=0xDEADBEEF, mie_clear_o=1.
  - Expect: redirect_pc_o=0x2000 held until ready.
- MRET with mepc_i=0x344:
  - Expect: mie_restore_o pulse, csr_trap_we_o=0, redirect_pc_o=0x344, trap_count_o unchanged.
- irq_i=1 with mie_i=1 and wb_valid, wb_next_pc=0x204:
  - Expect: entry no earlier than 2 cycles after assertion, mepc=0x204, mcause=0x8000000B.
  - Repeat with mie_i=0: no entry.
- Simultaneous trap+mret+irq in the same WB cycle:
  - Expect: TRAP taken, irq stays pending and is taken on the first IDLE cycle after the handshake.
- Hold redirect_ready_i=0 for 5 cycles:
  - Expect: redirect_valid_o, redirect_pc_o and flush_o stable for all 5 cycles; IDLE 1 cycle after ready.
- Assert rst_ni low in REDIRECT, and separately force 0xFFFF+2 trap entries:
  - Expect: all outputs 0 immediately, no strobe after release.
  - Expect: trap_count_o saturates at 0xFFFF.
